// File: rtl/step_skew_buffer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// step_skew_buffer_if : config handshake, per-lane stream in/out and status
// Revision 1.0
// ----------------------------------------------------------------------------
interface step_skew_buffer_if #(
    parameter int WORD_WIDTH  = 16,
    parameter int TUSER_WIDTH = 8,
    parameter int STEPS       = 8,
    parameter int MAX_STEP    = 6
);
    localparam int SW = $clog2(MAX_STEP + 1);

    logic                   aclken;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_is_1x1;
    logic [SW-1:0]          cfg_step;
    logic [STEPS-1:0]       s_valid;
    logic [STEPS-1:0]       s_last;
    logic [WORD_WIDTH-1:0]  s_data [STEPS];
    logic [TUSER_WIDTH-1:0] s_user [STEPS];
    logic [STEPS-1:0]       m_valid;
    logic [STEPS-1:0]       m_last;
    logic [WORD_WIDTH-1:0]  m_data [STEPS];
    logic [TUSER_WIDTH-1:0] m_user [STEPS];
    logic                   busy;
    logic                   cur_is_1x1;
    logic [SW-1:0]          cur_step;

    modport slave (
        input  aclken, cfg_valid, cfg_is_1x1, cfg_step,
        input  s_valid, s_last, s_data, s_user,
        output cfg_ready, m_valid, m_last, m_data, m_user,
        output busy, cur_is_1x1, cur_step
    );

    modport master (
        output aclken, cfg_valid, cfg_is_1x1, cfg_step,
        output s_valid, s_last, s_data, s_user,
        input  cfg_ready, m_valid, m_last, m_data, m_user,
        input  busy, cur_is_1x1, cur_step
    );
endinterface
`default_nettype wire

// File: rtl/step_skew_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// step_skew_buffer : per-lane delay line with runtime step, config taken only when drained
// Revision 1.0
// ----------------------------------------------------------------------------
module step_skew_buffer #(
    parameter int WORD_WIDTH   = 16,
    parameter int TUSER_WIDTH  = 8,
    parameter int STEPS        = 8,
    parameter int MAX_STEP     = 6,
    parameter int DEFAULT_STEP = 4
) (
    input  wire logic        aclk,
    input  wire logic        areset,
    step_skew_buffer_if.slave bus
);
    localparam int SW = $clog2(MAX_STEP + 1);
    localparam int BW = 2 + WORD_WIDTH + TUSER_WIDTH;
    localparam logic [SW-1:0] STEP_SAT = SW'(MAX_STEP);

    logic             cur_is_1x1_q, cur_is_1x1_d;
    logic [SW-1:0]    cur_step_q, cur_step_d;
    logic [STEPS-1:0] w_lane_busy;
    logic             w_busy;
    logic             w_cfg_fire;

    assign w_busy        = |w_lane_busy;
    assign bus.cfg_ready = bus.aclken & ~w_busy;
    assign w_cfg_fire    = bus.cfg_valid & bus.cfg_ready;

    always_comb begin
        cur_is_1x1_d = cur_is_1x1_q;
        cur_step_d   = cur_step_q;
        if (w_cfg_fire) begin
            cur_is_1x1_d = bus.cfg_is_1x1;
            cur_step_d   = (bus.cfg_step > STEP_SAT) ? STEP_SAT : bus.cfg_step;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_is_1x1_q <= 1'b1;
            cur_step_q   <= SW'(DEFAULT_STEP);
        end else begin
            cur_is_1x1_q <= cur_is_1x1_d;
            cur_step_q   <= cur_step_d;
        end
    end

    assign bus.busy       = w_busy;
    assign bus.cur_is_1x1 = cur_is_1x1_q;
    assign bus.cur_step   = cur_step_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_lane
        // Sized for the largest step so a config change never needs to resize.
        localparam int LEN = 1 + i * MAX_STEP;

        logic [BW-1:0] stg_q [LEN];
        logic [BW-1:0] w_tap_word;
        logic          w_any_vld;
        int            w_tap_idx;

        always_ff @(posedge aclk) begin
            if (areset) begin
                for (int k = 0; k < LEN; k++) begin
                    stg_q[k] <= '0;
                end
            end else if (bus.aclken) begin
                stg_q[0] <= {bus.s_valid[i], bus.s_last[i], bus.s_data[i], bus.s_user[i]};
                for (int k = 1; k < LEN; k++) begin
                    stg_q[k] <= stg_q[k-1];
                end
            end
        end

        always_comb begin
            w_tap_idx  = cur_is_1x1_q ? 0 : i * int'(cur_step_q);
            w_tap_word = '0;
            w_any_vld  = 1'b0;
            for (int k = 0; k < LEN; k++) begin
                if (k == w_tap_idx) begin
                    w_tap_word = stg_q[k];
                end
                w_any_vld = w_any_vld | stg_q[k][BW-1];
            end
        end

        assign w_lane_busy[i] = w_any_vld;
        assign bus.m_valid[i] = w_tap_word[BW-1];
        assign bus.m_last[i]  = w_tap_word[BW-2];
        assign bus.m_data[i]  = w_tap_word[TUSER_WIDTH +: WORD_WIDTH];
        assign bus.m_user[i]  = w_tap_word[TUSER_WIDTH-1:0];
    end
endmodule
`default_nettype wire
